ad9363_rx_delay_cal: RTL
========================

# ad9363_rx_delay_cal

Calibrates the receive-path IDELAY tap of the AD9363 LVDS interface and holds the user clock enable while it works. It sweeps all 32 taps in order, sampling `rx_status` at each tap and recording the longest run of passing taps. It then loads the centre tap of that run. It sits beside the AD9363 LVDS interface block, on `user_clk`, and drives that block's `rx_delay_value`, `rx_delay_load_en` and `data_clk_ce` inputs.

## Interface
- `SETTLE_CYCLES`, 64: cycles to wait after a tap load before checking starts.
- `CHECK_CYCLES`, 1024: number of `adc_valid` cycles that must be observed per tap.
- `TIMEOUT_CYCLES`, 4096: raw-cycle limit for the check window of one tap.
- `MIN_EYE`, 4: minimum passing-run length for a successful calibration.
- `DEFAULT_TAP`, 16: tap loaded when calibration fails.

Ports:
- `user_clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `cal_start` in 1: single-cycle request to start or restart calibration.
- `adc_valid` in 1: receive sample strobe from the interface.
- `rx_status` in 1: receive-data-correct flag from the interface.
- `rx_delay_value` out 5: tap value presented to the IDELAY.
- `rx_delay_load_en` out 1: one-cycle load strobe for `rx_delay_value`.
- `data_clk_ce` out 1: user clock enable; high only in DONE and FAIL.
- `cal_busy` out 1: calibration in progress.
- `cal_done` out 1: level; the last calibration succeeded.
- `cal_fail` out 1: level; the last calibration failed.
- `eye_start` out 5: first tap of the best passing run.
- `eye_width` out 6: length of the best run, 0 to 32.

## Operation
- States: IDLE, LOAD, SETTLE, CHECK, EVAL, FINAL, LOAD_FINAL, DONE, FAIL.
- IDLE → LOAD on `cal_start`. Entering LOAD from IDLE, DONE or FAIL clears tap to 0, run_len, run_start, best_len and best_start, and drops `data_clk_ce`.
- LOAD (1 cycle): `rx_delay_value` = tap and `rx_delay_load_en` = 1. Go to SETTLE.
- SETTLE: count `SETTLE_CYCLES` cycles, then go to CHECK.
- CHECK:
  - Counts `adc_valid` cycles (valid_cnt) and all cycles (raw_cnt).
  - The tap fails if any cycle has `adc_valid`=1 and `rx_status`=0.
  - The tap also fails if raw_cnt reaches `TIMEOUT_CYCLES` before valid_cnt reaches `CHECK_CYCLES`.
  - Exit to EVAL when valid_cnt = `CHECK_CYCLES`, or on timeout.
- EVAL (1 cycle):
  - Passing tap: if run_len = 0 then run_start = tap; run_len++.
  - If run_len (after increment) > best_len: best_len = run_len and best_start = run_start. The comparison is strict, so the lowest-tap run wins a tie.
  - Failing tap: run_len = 0.
  - If tap = 31, go to FINAL. Otherwise tap++ and go to LOAD.
  - Runs do not wrap from tap 31 to tap 0.
- FINAL (1 cycle):
  - If best_len ≥ `MIN_EYE`: final tap = best_start + ((best_len − 1) >> 1), computed in 6-bit arithmetic and truncated to 5 bits.
  - Otherwise: final tap = `DEFAULT_TAP`.
  - Go to LOAD_FINAL.
- LOAD_FINAL (1 cycle): pulse `rx_delay_load_en` with the final tap, then go to DONE or FAIL.
- DONE / FAIL:
  - `data_clk_ce` = 1.
  - `eye_start` and `eye_width` are latched from best_start and best_len.
  - `cal_done` (DONE) or `cal_fail` (FAIL) is held high.
  - `cal_start` restarts calibration.
- `cal_start` while `cal_busy` = 1 is ignored.
- `cal_busy` = 1 in every state except IDLE, DONE and FAIL.
- `cal_done` and `cal_fail` clear on the cycle that LOAD is entered.
- `rx_delay_value` holds its last loaded value between loads.

## Timing
- Reset values: state IDLE; `rx_delay_value` 0; `rx_delay_load_en` 0; `data_clk_ce` 0; `cal_busy` 0; `cal_done` 0; `cal_fail` 0; `eye_start` 0; `eye_width` 0.
- A reset in any state takes effect on the next edge and aborts calibration. No load pulse is issued.
- `cal_start` sampled at edge N → `rx_delay_load_en` high in cycle N+1 with tap 0.
- Per tap, with `adc_valid` continuously high: 1 + `SETTLE_CYCLES` + `CHECK_CYCLES` + 1 cycles.
- After EVAL of tap 31: FINAL, then LOAD_FINAL, then DONE/FAIL, with status outputs high 3 cycles after EVAL.
- `rx_delay_load_en` is never high for 2 consecutive cycles.
- A fail in the last cycle of CHECK (the valid_cnt-terminal cycle) counts.

## Test plan
- All 32 taps pass → `eye_start`=0, `eye_width`=32, final load 15, `cal_done`=1, `data_clk_ce`=1.
- `rx_status` low only outside taps 10–20 → `eye_start`=10, `eye_width`=11, final load 15.
- Passing runs at taps 3–6 and 20–27 → `eye_start`=20, `eye_width`=8, final load 23. Equal runs at 2–5 and 9–12 → `eye_start`=2.
- Best run of 3 taps, or no passing tap → `cal_fail`=1, final load 16, `data_clk_ce`=1.
- `adc_valid` stuck low → every tap times out after 4096 cycles → `cal_fail`=1, `eye_width`=0.
- `rst` asserted during CHECK of tap 7 → next cycle all outputs at reset values. A `cal_start` pulse while busy changes nothing. A `cal_start` in DONE restarts with a load of tap 0.

Source files
------------

// File: rtl/ad9363_rx_delay_cal.sv
// AD9363 receive IDELAY calibration: sweeps all 32 taps and finds the widest
// passing eye. It then loads the eye centre and releases the user clock enable.
module ad9363_rx_delay_cal #(
  parameter int SETTLE_CYCLES  = 64,
  parameter int CHECK_CYCLES   = 1024,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MIN_EYE        = 4,
  parameter int DEFAULT_TAP    = 16
) (
  input  logic       user_clk,
  input  logic       rst,
  input  logic       cal_start,
  input  logic       adc_valid,
  input  logic       rx_status,
  output logic [4:0] rx_delay_value,
  output logic       rx_delay_load_en,
  output logic       data_clk_ce,
  output logic       cal_busy,
  output logic       cal_done,
  output logic       cal_fail,
  output logic [4:0] eye_start,
  output logic [5:0] eye_width
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int VW = (CHECK_CYCLES > 1) ? $clog2(CHECK_CYCLES) : 1;
  localparam int RW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CHECK,
    S_EVAL,
    S_FINAL,
    S_LOAD_FINAL,
    S_DONE,
    S_FAIL
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [4:0]    r_tap;
  logic [4:0]    r_run_start;
  logic [4:0]    r_best_start;
  logic [4:0]    r_dly;
  logic [4:0]    r_eye_start;
  logic [5:0]    r_run_len;
  logic [5:0]    r_best_len;
  logic [5:0]    r_eye_width;
  logic [SW-1:0] r_settle_cnt;
  logic [VW-1:0] r_valid_cnt;
  logic [RW-1:0] r_raw_cnt;
  logic          r_bad;
  logic          r_load_en;
  logic          r_ce;
  logic          r_busy;
  logic          r_done;
  logic          r_fail;

  logic          w_settle_end;
  logic          w_valid_end;
  logic          w_timeout;
  logic          w_eye_ok;
  logic          w_pass;
  logic [5:0]    w_run_len_inc;
  logic [4:0]    w_run_start_new;
  logic [5:0]    w_center;

  assign w_settle_end    = (r_settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign w_valid_end     = adc_valid &&
                           (r_valid_cnt == VW'(CHECK_CYCLES - 1));
  assign w_timeout       = (r_raw_cnt == RW'(TIMEOUT_CYCLES - 1));
  assign w_eye_ok        = (r_best_len >= 6'(MIN_EYE));
  assign w_pass          = !r_bad;
  assign w_run_len_inc   = r_run_len + 6'd1;
  assign w_run_start_new = (r_run_len == 6'd0) ? r_tap : r_run_start;
  assign w_center        = {1'b0, r_best_start} +
                           ((r_best_len - 6'd1) >> 1);

  always_ff @(posedge user_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (cal_start) w_next = S_LOAD;
      end
      S_LOAD:   w_next = S_SETTLE;
      S_SETTLE: begin
        if (w_settle_end) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_valid_end || w_timeout) w_next = S_EVAL;
      end
      S_EVAL:       w_next = (r_tap == 5'd31) ? S_FINAL : S_LOAD;
      S_FINAL:      w_next = S_LOAD_FINAL;
      S_LOAD_FINAL: w_next = w_eye_ok ? S_DONE : S_FAIL;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (rst) begin
      r_tap        <= '0;
      r_run_start  <= '0;
      r_best_start <= '0;
      r_dly        <= '0;
      r_eye_start  <= '0;
      r_run_len    <= '0;
      r_best_len   <= '0;
      r_eye_width  <= '0;
      r_settle_cnt <= '0;
      r_valid_cnt  <= '0;
      r_raw_cnt    <= '0;
      r_bad        <= 1'b0;
      r_load_en    <= 1'b0;
      r_ce         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_load_en <= (w_next == S_LOAD) || (w_next == S_LOAD_FINAL);
      r_ce      <= (w_next == S_DONE) || (w_next == S_FAIL);
      r_busy    <= !((w_next == S_IDLE) || (w_next == S_DONE) ||
                     (w_next == S_FAIL));
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (cal_start) begin
            r_tap        <= '0;
            r_run_len    <= '0;
            r_run_start  <= '0;
            r_best_len   <= '0;
            r_best_start <= '0;
            r_dly        <= '0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
          end
        end
        S_LOAD: begin
          r_settle_cnt <= '0;
          r_valid_cnt  <= '0;
          r_raw_cnt    <= '0;
          r_bad        <= 1'b0;
        end
        S_SETTLE: begin
          r_settle_cnt <= r_settle_cnt + SW'(1);
        end
        S_CHECK: begin
          r_raw_cnt <= r_raw_cnt + RW'(1);
          if (adc_valid) r_valid_cnt <= r_valid_cnt + VW'(1);
          // A bad sample on the terminal valid cycle still fails the tap
          if ((adc_valid && !rx_status) || (w_timeout && !w_valid_end))
            r_bad <= 1'b1;
        end
        S_EVAL: begin
          if (w_pass) begin
            r_run_len   <= w_run_len_inc;
            r_run_start <= w_run_start_new;
            if (w_run_len_inc > r_best_len) begin
              r_best_len   <= w_run_len_inc;
              r_best_start <= w_run_start_new;
            end
          end else begin
            r_run_len <= '0;
          end
          if (r_tap != 5'd31) begin
            r_tap <= r_tap + 5'd1;
            r_dly <= r_tap + 5'd1;
          end
        end
        S_FINAL: begin
          r_dly <= w_eye_ok ? w_center[4:0] : 5'(DEFAULT_TAP);
        end
        S_LOAD_FINAL: begin
          r_eye_start <= r_best_start;
          r_eye_width <= r_best_len;
          r_done      <= w_eye_ok;
          r_fail      <= !w_eye_ok;
        end
        default: ;
      endcase
    end
  end

  assign rx_delay_value   = r_dly;
  assign rx_delay_load_en = r_load_en;
  assign data_clk_ce      = r_ce;
  assign cal_busy         = r_busy;
  assign cal_done         = r_done;
  assign cal_fail         = r_fail;
  assign eye_start        = r_eye_start;
  assign eye_width        = r_eye_width;

endmodule
